// File: rtl/serial_sub_4bit_if.sv
// Handshake and data bundle for the bit-serial 4-bit subtractor.
interface serial_sub_4bit_if;
  localparam int unsigned W = 4;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;

  // Requester side: issues operands and start, observes status and result.
  modport master (
    output start, a, b,
    input  busy, done, d, bout
  );

  // Subtractor side.
  modport slave (
    input  start, a, b,
    output busy, done, d, bout
  );
endinterface

// File: rtl/serial_sub_4bit.sv
// Bit-serial 4-bit unsigned subtractor: one bit per cycle, LSB first, result after 5 cycles.
module serial_sub_4bit (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_sub_4bit_if.slave       bus
);
  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_busy_nxt;
  logic           w_done_nxt;

  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_res;
  logic [CW-1:0]  r_cnt;
  logic           r_br;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_d;
  logic           r_bout;

  logic           w_dbit;
  logic           w_br_nxt;
  logic [W-1:0]   w_res_full;
  logic           w_last;

  // Full-subtractor slice on the current LSBs of the shifting operands.
  assign w_dbit     = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_nxt   = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_res_full = {w_dbit, r_res[W-1:1]};
  assign w_last     = (r_cnt == CW'(W - 1));

  // State register plus registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state decode; status flags follow the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:                 w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Operand capture, serial datapath and result/borrow output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_cnt  <= '0;
      r_br   <= 1'b0;
      r_d    <= '0;
      r_bout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_br  <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_a   <= {1'b0, r_a[W-1:1]};
          r_b   <= {1'b0, r_b[W-1:1]};
          r_br  <= w_br_nxt;
          r_res <= w_res_full;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_d    <= w_res_full;
            r_bout <= w_br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.d    = r_d;
  assign bus.bout = r_bout;
endmodule

// File: tb/tb_serial_sub_4bit.sv
// Directed bench for serial_sub_4bit: vector table, sweep and multi-cycle corner sequences.
module tb_serial_sub_4bit;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_sub_4bit_if bus();

  serial_sub_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       bout;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and sample just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation from IDLE with latency, busy width and result checks.
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib,
                        input logic [3:0] ed, input logic eb, input string tag);
    int lat;
    int nbusy;
    bus.a = ia;
    bus.b = ib;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 1;
    nbusy = bus.busy ? 1 : 0;
    while (!bus.done && lat < 10) begin
      step();
      lat++;
      if (bus.busy) nbusy++;
    end
    check({tag, " latency"}, lat, 5);
    check({tag, " busy_cycles"}, nbusy, 4);
    check({tag, " d"}, bus.d, ed);
    check({tag, " bout"}, bus.bout, eb);
    step();
    check({tag, " done_pulse_end"}, bus.done, 0);
  endtask

  initial begin
    int   gap;
    int   ndone;
    logic [3:0] sa, sb, ea;
    logic [4:0] diff;

    n_cmp = 0;
    n_err = 0;

    vecs[0]  = '{4'd9,  4'd5,  4'd4,  1'b0};
    vecs[1]  = '{4'd5,  4'd9,  4'd12, 1'b1};
    vecs[2]  = '{4'd0,  4'd1,  4'd15, 1'b1};
    vecs[3]  = '{4'd15, 4'd15, 4'd0,  1'b0};
    vecs[4]  = '{4'd0,  4'd0,  4'd0,  1'b0};
    vecs[5]  = '{4'd3,  4'd7,  4'd12, 1'b1};
    vecs[6]  = '{4'd6,  4'd2,  4'd4,  1'b0};
    vecs[7]  = '{4'd8,  4'd1,  4'd7,  1'b0};
    vecs[8]  = '{4'd1,  4'd8,  4'd9,  1'b1};
    vecs[9]  = '{4'd15, 4'd0,  4'd15, 1'b0};
    vecs[10] = '{4'd0,  4'd15, 4'd1,  1'b1};
    vecs[11] = '{4'd10, 4'd3,  4'd7,  1'b0};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = 4'd0;
    bus.b = 4'd0;
    #12;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset d", bus.d, 0);
    check("reset bout", bus.bout, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bout, $sformatf("vec%0d", i));

    // Start held high: every (a,b) pair, one result every 6 cycles.
    bus.a = 4'd0;
    bus.b = 4'd0;
    bus.start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sa = bus.a;
      sb = bus.b;
      gap = 0;
      do begin
        step();
        gap++;
      end while (!bus.done && gap < 12);
      check("sweep interval", gap, (i == 0) ? 5 : 6);
      diff = {1'b0, sa} - {1'b0, sb};
      if (bus.d != diff[3:0] || bus.bout != diff[4]) begin
        check($sformatf("sweep a=%0d b=%0d", sa, sb), {27'd0, bus.bout, bus.d}, {27'd0, diff[4], diff[3:0]});
      end else begin
        n_cmp++;
      end
      if (i < 255) begin
        ea = 4'(i + 1);
        bus.a = 4'((i + 1) >> 4);
        bus.b = ea;
      end
    end
    bus.start = 1'b0;
    step();
    step();

    // Start and operand changes during RUN/DONE must be ignored.
    bus.a = 4'd3;
    bus.b = 4'd7;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1; bus.a = 4'd15; bus.b = 4'd0;
    step();
    bus.start = 1'b0; bus.a = 4'd0; bus.b = 4'd15;
    step();
    bus.a = 4'd9;
    step();
    check("ignore done", bus.done, 1);
    check("ignore d", bus.d, 12);
    check("ignore bout", bus.bout, 1);
    bus.start = 1'b1; bus.a = 4'd15; bus.b = 4'd0;
    step();
    bus.start = 1'b0;
    ndone = 0;
    gap = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done) ndone++;
      if (bus.busy) gap++;
      step();
    end
    check("ignore no_second_done", ndone, 0);
    check("ignore no_second_busy", gap, 0);
    check("ignore d_held", bus.d, 12);

    // Asynchronous reset in the middle of RUN.
    bus.a = 4'd9;
    bus.b = 4'd5;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", bus.busy, 0);
    check("abort done", bus.done, 0);
    check("abort d", bus.d, 0);
    check("abort bout", bus.bout, 0);
    #4;
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.done) ndone++;
    end
    check("abort no_done", ndone, 0);
    run_op(4'd6, 4'd2, 4'd4, 1'b0, "after_abort");

    // Result must hold while idle.
    ndone = 0;
    gap = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.done) ndone++;
      if (bus.d != 4'd4 || bus.bout != 1'b0) gap++;
    end
    check("hold done_count", ndone, 0);
    check("hold changes", gap, 0);
    check("hold d", bus.d, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
